// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient}.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;      // dividend magnitude, shifts left and collects quotient bits
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic             neg_q_q;
  logic             neg_r_q;

  logic             accept_c;
  logic             abort_c;
  logic             last_c;
  logic             op1_neg_c;
  logic             op2_neg_c;
  logic [WIDTH-1:0] mag1_c;
  logic [WIDTH-1:0] mag2_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;
  logic             qbit_c;
  logic [WIDTH-1:0] step_rem_c;
  logic [WIDTH-1:0] step_quo_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  // Operand magnitudes and one shift-subtract step of the restoring divider
  always_comb begin
    op1_neg_c  = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg_c  = signed_div_i & opdata2_i[WIDTH-1];
    mag1_c     = op1_neg_c ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    mag2_c     = op2_neg_c ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    shifted_c  = {rem_q, dvd_q[WIDTH-1]};
    trial_c    = shifted_c - {1'b0, dvs_q};
    qbit_c     = ~trial_c[WIDTH];
    step_rem_c = qbit_c ? trial_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
    step_quo_c = {dvd_q[WIDTH-2:0], qbit_c};
    quo_fix_c  = neg_q_q ? (~step_quo_c + WIDTH'(1)) : step_quo_c;
    rem_fix_c  = neg_r_q ? (~step_rem_c + WIDTH'(1)) : step_rem_c;
    accept_c   = start_i & ~annul_i;
    abort_c    = annul_i | ~start_i;
    last_c     = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; END always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_c) state_d = (opdata2_i == '0) ? S_ZERO : S_ON;
      S_ZERO: state_d = abort_c ? S_IDLE : S_END;
      S_ON: begin
        if (abort_c)     state_d = S_IDLE;
        else if (last_c) state_d = S_END;
      end
      S_END:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            // Divide-by-zero keeps the raw dividend: it is returned unmodified as HI
            dvd_q   <= (opdata2_i == '0) ? opdata1_i : mag1_c;
            dvs_q   <= mag2_c;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= op1_neg_c ^ op2_neg_c;
            neg_r_q <= op1_neg_c;
          end
        end
        S_ON: begin
          if (!abort_c) begin
            rem_q <= step_rem_c;
            dvd_q <= step_quo_c;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: result loaded only on END entry, ready high while in END
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= (state_d == S_END);
      if (state_q == S_ON && state_d == S_END)
        result_o <= {rem_fix_c, quo_fix_c};
      else if (state_q == S_ZERO && state_d == S_END)
        result_o <= {dvd_q, {WIDTH{1'b1}}};
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of divisions plus abort, back-to-back and reset sequences.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic           clk;
  logic           resetn;
  logic           start_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge: drive a request, accepted at the following posedge
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Count negedges until ready_o; optionally scramble operands at a given cycle
  task automatic wait_ready(input int limit, input int scramble_at,
                            output int lat, output logic [63:0] res);
    lat = 0;
    res = '0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == scramble_at) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (ready_o) begin
        lat = n;
        res = result_o;
        break;
      end
    end
  endtask

  int          lat;
  logic [63:0] res;
  logic [63:0] prev;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2};
    vecs[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  2};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[11] = '{1'b0, 32'd1000000,    32'd1000,       32'd1000,       32'd0,          33};
    vecs[12] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          33};
    vecs[13] = '{1'b1, 32'hFFFF_FFF9,  32'd7,          32'hFFFF_FFFF,  32'd0,          33};

    resetn       = 1'b0;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Table of directed divisions
    foreach (vecs[i]) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_ready(40, 0, lat, res);
      start_i = 1'b0;
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_result", i), res, {vecs[i].r, vecs[i].q});
      @(negedge clk);
      chk($sformatf("vec%0d_ready_pulse", i), 64'(ready_o), 64'd0);
    end

    // Annul at cycle 10: no ready, result unchanged, restart two cycles later
    prev = {32'd0, 32'hFFFF_FFFF};
    start_op(1'b0, 32'd1234, 32'd5);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ready_o) chk("annul_early_ready", 64'(ready_o), 64'd0);
    end
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk("annul_no_ready", 64'(ready_o), 64'd0);
    chk("annul_result_kept", result_o, prev);
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(40, 0, lat, res);
    start_i = 1'b0;
    chk("after_annul_latency", 64'(lat), 64'd33);
    chk("after_annul_result", res, {32'd2, 32'd14});
    @(negedge clk);

    // Back-to-back with start held high and operands scrambled mid-run
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(40, 3, lat, res);
    chk("b2b_first_latency", 64'(lat), 64'd33);
    chk("b2b_first_result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    opdata1_i = 32'd7;
    opdata2_i = 32'hFFFF_FFFE;
    wait_ready(40, 10, lat, res);
    start_i = 1'b0;
    chk("b2b_second_gap", 64'(lat), 64'd34);
    chk("b2b_second_result", res, {32'd1, 32'hFFFF_FFFD});
    @(negedge clk);
    chk("b2b_ready_pulse", 64'(ready_o), 64'd0);

    // Async reset at cycle 20 of an operation
    start_op(1'b0, 32'd100, 32'd7);
    repeat (20) @(negedge clk);
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    chk("midreset_result", result_o, 64'd0);
    chk("midreset_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("postreset_idle_ready", 64'(ready_o), 64'd0);
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(40, 0, lat, res);
    start_i = 1'b0;
    chk("postreset_latency", 64'(lat), 64'd33);
    chk("postreset_result", res, {32'd2, 32'd14});
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
